// File: rtl/tx_packet_controller.sv
// Serial packet transmitter: SYNC, PID, FIFO payload and inverted CRC16, sent LSB first
// one bit per downstream bit_ready strobe, closed by a two-strobe EOP.
module tx_packet_controller (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        tx_start,
  input  logic [3:0]  pid,
  input  logic [6:0]  byte_count,
  input  logic [7:0]  fifo_data,
  input  logic        fifo_empty,
  output logic        fifo_read,
  input  logic        bit_ready,
  input  logic [15:0] crc_bytes,
  output logic        crc_reset,
  output logic        crc_new_bit,
  output logic        crc_bit,
  output logic        tx_bit,
  output logic        tx_valid,
  output logic        tx_eop,
  output logic        busy,
  output logic        done,
  output logic        error
);

  typedef enum logic [3:0] {
    IDLE, SYNC, PID, LOAD, DATA, CRC_WAIT, CRC, EOP, DONE
  } state_t;

  state_t      state_q;
  logic [3:0]  pid_q;
  logic [6:0]  bytes_q;
  logic [3:0]  bitcnt_q;
  logic [15:0] sh_q;
  logic        is_data;

  assign is_data = (pid_q == 4'b0011) || (pid_q == 4'b1011);

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_q  <= IDLE;
      pid_q    <= '0;
      bytes_q  <= '0;
      bitcnt_q <= '0;
      sh_q     <= '0;
    end else begin
      case (state_q)
        IDLE: if (tx_start) begin
          pid_q    <= pid;
          bytes_q  <= (byte_count > 7'd64) ? 7'd64 : byte_count;
          sh_q     <= 16'h0080;
          bitcnt_q <= '0;
          state_q  <= SYNC;
        end
        SYNC: if (bit_ready) begin
          if (bitcnt_q == 4'd7) begin
            sh_q     <= {8'h00, ~pid_q, pid_q};
            bitcnt_q <= '0;
            state_q  <= PID;
          end else begin
            sh_q     <= {1'b0, sh_q[15:1]};
            bitcnt_q <= bitcnt_q + 4'd1;
          end
        end
        PID: if (bit_ready) begin
          sh_q <= {1'b0, sh_q[15:1]};
          if (bitcnt_q == 4'd7) begin
            bitcnt_q <= '0;
            if (!is_data)            state_q <= EOP;
            else if (bytes_q != '0)  state_q <= LOAD;
            else                     state_q <= CRC_WAIT;
          end else begin
            bitcnt_q <= bitcnt_q + 4'd1;
          end
        end
        LOAD: begin
          bitcnt_q <= '0;
          if (!fifo_empty) begin
            sh_q    <= {8'h00, fifo_data};
            bytes_q <= bytes_q - 7'd1;
            state_q <= DATA;
          end else begin
            state_q <= EOP;
          end
        end
        DATA: if (bit_ready) begin
          sh_q <= {1'b0, sh_q[15:1]};
          if (bitcnt_q == 4'd7) begin
            bitcnt_q <= '0;
            state_q  <= (bytes_q != '0) ? LOAD : CRC_WAIT;
          end else begin
            bitcnt_q <= bitcnt_q + 4'd1;
          end
        end
        CRC_WAIT: begin
          sh_q     <= ~crc_bytes;
          bitcnt_q <= '0;
          state_q  <= CRC;
        end
        CRC: if (bit_ready) begin
          sh_q <= {1'b0, sh_q[15:1]};
          if (bitcnt_q == 4'd15) begin
            bitcnt_q <= '0;
            state_q  <= EOP;
          end else begin
            bitcnt_q <= bitcnt_q + 4'd1;
          end
        end
        EOP: if (bit_ready) begin
          if (bitcnt_q == 4'd1) begin
            bitcnt_q <= '0;
            state_q  <= DONE;
          end else begin
            bitcnt_q <= bitcnt_q + 4'd1;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Strobes are gated by n_rst so a reset cycle never pops, clears or pulses anything.
  always_comb begin
    tx_valid    = (state_q != IDLE) && (state_q != DONE);
    busy        = tx_valid;
    tx_eop      = (state_q == EOP);
    done        = n_rst && (state_q == DONE);
    tx_bit      = (tx_valid && !tx_eop) ? sh_q[0] : 1'b1;
    crc_reset   = n_rst && (state_q == IDLE) && tx_start;
    fifo_read   = n_rst && (state_q == LOAD) && !fifo_empty;
    error       = n_rst && (state_q == LOAD) && fifo_empty;
    crc_new_bit = n_rst && (state_q == DATA) && bit_ready;
    crc_bit     = crc_new_bit & sh_q[0];
  end

endmodule

// File: doc/tx_packet_controller.md
TX_PACKET_CONTROLLER -- requirements
Module: tx_packet_controller

Interface
REQ-001 SHALL: one clock; reset is synchronous and active-low.
REQ-002 SHALL: clk  in  1  system clock; all state changes on rising edge.
REQ-003 SHALL: n_rst  in  1  synchronous active-low reset.
REQ-004 SHALL: tx_start  in  1  packet request; sampled only in IDLE.
REQ-005 SHALL: pid  in  4  packet ID nibble; sampled with tx_start.
REQ-006 SHALL: byte_count  in  7  payload length 0..64; sampled with tx_start; values >64 are treated as 64.
REQ-007 SHALL: fifo_data  in  8  show-ahead payload byte, valid while fifo_empty=0.
REQ-008 SHALL: fifo_empty  in  1  payload FIFO empty.
REQ-009 SHALL: fifo_read  out  1  one-cycle pop strobe.
REQ-010 SHALL: bit_ready  in  1  downstream consumed tx_bit this cycle; at most one strobe per 4 clocks.
REQ-011 SHALL: crc_bytes  in  16  running CRC16 value from the CRC unit.
REQ-012 SHALL: crc_reset, crc_new_bit, crc_bit  out  1 each  CRC unit sync clear, shift strobe, shift data.
REQ-013 SHALL: tx_bit, tx_valid, tx_eop  out  1 each  serial bit, line active, SE0 request.
REQ-014 SHALL: busy, done, error  out  1 each  packet in progress, completion pulse, FIFO underrun pulse.

Function
REQ-015 SHALL: states IDLE, SYNC, PID, LOAD, DATA, CRC_WAIT, CRC, EOP, DONE.
REQ-016 SHALL: IDLE with tx_start=1 -> SYNC; same cycle pulse crc_reset=1; latch pid and clamped byte_count.
REQ-017 SHALL: all bytes sent LSB first; one bit advanced per bit_ready strobe; tx_bit changes only on the edge after a strobe.
REQ-018 SHALL: SYNC sends 8'h80 (bits 0,0,0,0,0,0,0,1) then -> PID.
REQ-019 SHALL: PID sends {~pid,pid} (8 bits); afterwards DATA0/DATA1 pid (4'b0011/4'b1011) -> LOAD if byte counter >0 else CRC_WAIT; any other pid -> EOP.
REQ-020 SHALL: LOAD, fifo_empty=0: fifo_read=1 for one cycle, fifo_data captured into byte shift register, decrement byte counter, -> DATA.
REQ-021 SHALL: LOAD, fifo_empty=1: error=1 for one cycle, no fifo_read, -> EOP (packet aborted, no CRC sent).
REQ-022 SHALL: DATA: each bit_ready strobe asserts crc_new_bit=1 and crc_bit=tx_bit in the same cycle; after 8th bit -> LOAD if byte counter >0 else CRC_WAIT.
REQ-023 SHALL: crc_new_bit=0 in every state other than DATA; SYNC, PID and CRC bits never feed the CRC unit.
REQ-024 SHALL: CRC_WAIT lasts exactly one cycle, then captures ~crc_bytes into a 16-bit shift register and -> CRC.
REQ-025 SHALL: CRC sends the 16 captured bits LSB first (bit 0 of ~crc_bytes first), then -> EOP.
REQ-026 SHALL: EOP holds tx_eop=1 for two bit_ready strobes, then -> DONE.
REQ-027 SHALL: DONE asserts done=1 for one cycle, -> IDLE.
REQ-028 SHALL: tx_valid=1 and busy=1 in all states except IDLE and DONE; busy=0 in DONE.
REQ-029 SHALL: bit_ready in IDLE, LOAD, CRC_WAIT, DONE is ignored (no bit advance).
REQ-030 SHALL: tx_start while busy is ignored; tx_start in DONE is ignored.
REQ-031 SHALL: tx_bit=1 (idle J) whenever tx_valid=0 or tx_eop=1.

Reset
REQ-032 SHALL: n_rst=0 at a rising edge -> IDLE next cycle, regardless of current state, including mid-packet.
REQ-033 SHALL: reset values: fifo_read=0, crc_reset=0, crc_new_bit=0, crc_bit=0, tx_bit=1, tx_valid=0, tx_eop=0, busy=0, done=0, error=0; bit/byte counters and shift registers 0.
REQ-034 SHALL: reset mid-packet pops no further FIFO bytes and produces no done or error pulse.

Verification
REQ-035 SHALL: handshake pid=4'h2 (ACK), byte_count=5 -> SYNC 8 bits, PID byte 8'hD2, EOP 2 strobes, done; zero fifo_read, zero crc_new_bit.
REQ-036 SHALL: DATA0, byte_count=2, FIFO 8'hA5,8'h01, crc_bytes=16'h1234 at CRC_WAIT -> 16 crc_new_bit strobes with bits of A5 then 01 LSB first, CRC bits of 16'hEDCB LSB first, 2 fifo_read pulses.
REQ-037 SHALL: DATA1, byte_count=0 -> PID 8'h4B directly followed by 16 CRC bits; no fifo_read; crc_reset pulse at start.
REQ-038 SHALL: DATA0, byte_count=3, FIFO empties after 1 byte -> error pulse in second LOAD, EOP, done; no CRC bits sent.
REQ-039 SHALL: n_rst=0 during 10th DATA bit -> next cycle tx_valid=0, busy=0, tx_bit=1; subsequent tx_start starts cleanly with crc_reset pulse.
REQ-040 SHALL: byte_count=100 -> exactly 64 bytes popped; tx_start pulsed while busy -> no second packet.
